load_use_hazard_unit: RTL
=========================

Name: load_use_hazard_unit

Overview:
- Producer-side companion of the operand forwarding logic in the 5-stage MIPS pipeline.
- Carries each issued instruction's destination register, write enable and load flag through shadow ID/EX, EX/MEM and MEM/WB registers.
- Drives the EX/MEM and MEM/WB destination/enable signals consumed by forwarding.
- Detects load-use hazards at ID and inserts exactly one bubble, because a loaded value cannot be forwarded from EX/MEM.

Parameters:
- NB_ADDR, 5, register-file address width.
- NB_COUNT, 32, width of stall-cycle statistics counter.

Ports:
- i_clock  in  1  system clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  global pipeline advance (debug step / memory wait); low = freeze all state.
- i_valid_id  in  1  ID holds a real instruction.
- i_rs_id  in  NB_ADDR  rs field of instruction in ID.
- i_rt_id  in  NB_ADDR  rt field of instruction in ID.
- i_uses_rs_id  in  1  instruction in ID reads rs.
- i_uses_rt_id  in  1  instruction in ID reads rt.
- i_rd_id  in  NB_ADDR  destination register of instruction in ID (already muxed rt/rd/31).
- i_wr_enb_id  in  1  instruction in ID writes the register file.
- i_mem_read_id  in  1  instruction in ID is a load.
- i_flush  in  1  branch/jump taken; squash instruction in ID.
- o_stall  out  1  hold PC and IF/ID; bubble into ID/EX (combinational).
- o_rf_rd_ex_mem  out  NB_ADDR  destination in EX/MEM.
- o_rf_wr_enb_ex_mem  out  1  write enable in EX/MEM.
- o_rf_rd_mem_wb  out  NB_ADDR  destination in MEM/WB.
- o_rf_wr_enb_mem_wb  out  1  write enable in MEM/WB.
- o_pipe_empty  out  1  no valid entry in any shadow stage.
- o_stall_count  out  NB_COUNT  saturating count of stall cycles.

Behaviour:
- State: three stage entries {valid, rd, wr_enb, is_load}: ID/EX, EX/MEM, MEM/WB.
- Reset (synchronous, i_reset high at edge): all entries cleared to valid=0, rd=0, wr_enb=0, is_load=0; o_stall_count=0. Reset has priority over i_enable and aborts any in-flight stall. All outputs read 0 in the cycle after reset; o_pipe_empty=1.
- Effective write enable: wr_enb is stored as i_wr_enb_id & (i_rd_id != 0). Register 0 never appears as a forwarding source.
- Hazard (combinational) is asserted when all of the following hold:
  - i_valid_id;
  - ID/EX valid & is_load & wr_enb;
  - (i_uses_rs_id & i_rs_id == ID/EX.rd) | (i_uses_rt_id & i_rt_id == ID/EX.rd).
- o_stall = hazard & ~i_flush. Flush has priority: the squashed instruction needs no stall.
- Advance on each edge with i_enable=1:
  - MEM/WB <= EX/MEM; EX/MEM <= ID/EX.
  - ID/EX <= bubble (all zero) if i_flush | o_stall | ~i_valid_id; otherwise ID fields.
- Freeze: i_enable=0 holds every entry and the counter unchanged. o_stall is still computed from current state.
- Stall length: exactly one cycle per load-use pair. After the bubble, the load sits in EX/MEM, the hazard term deasserts, and forwarding serves the consumer from MEM/WB.
- Back-to-back loads each check only the current ID/EX. A load followed by a dependent load stalls once.
- rs and rt both matching the load's rd still gives a single one-cycle stall.
- No WB-stage tracking: the register file is write-first.
- Counter increments by 1 on each edge with i_enable & o_stall & ~i_reset. It holds at 2^NB_COUNT-1 (no wrap).
- o_pipe_empty = ~(ID/EX.valid | EX/MEM.valid | MEM/WB.valid), combinational from state.
- Outputs o_rf_* are direct register outputs: zero combinational path from ID inputs.

Test Plan:
- Reset: hold i_reset 2 cycles with random inputs -> all o_rf_* = 0, o_stall_count = 0, o_pipe_empty = 1.
- Load-use: issue lw rd=8, then add rs=8 -> o_stall=1 for exactly 1 cycle. ID/EX becomes a bubble. Next cycle o_rf_rd_ex_mem=8 and o_rf_wr_enb_ex_mem=1; the following cycle o_rf_rd_mem_wb=8. o_stall_count=1.
- Non-load producer: add rd=5, then sub rs=5 -> o_stall stays 0. Next cycle o_rf_rd_ex_mem=5 and o_rf_wr_enb_ex_mem=1.
- Register 0: lw rd=0, then add rs=0 -> no stall; o_rf_wr_enb_ex_mem=0 when the load reaches EX/MEM.
- Flush vs stall: lw rd=3, then consumer rt=3 with i_flush=1 in the same cycle -> o_stall=0. ID/EX gets a bubble; counter unchanged.
- Freeze and saturation:
  - Hold i_enable=0 for 4 cycles during a pending hazard -> entries unchanged, o_stall stays 1, counter unchanged.
  - With NB_COUNT=2, cause 5 stalls -> o_stall_count=3.

Source files
------------

// File: rtl/load_use_hazard_unit.sv
// Load-use hazard detection for the 5-stage pipeline. Shadow ID/EX, EX/MEM and MEM/WB
// destination tracking feeds forwarding. A load-use pair inserts a single bubble.
module load_use_hazard_unit #(
    parameter int NB_ADDR  = 5,
    parameter int NB_COUNT = 32
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_valid_id,
    input  logic [NB_ADDR-1:0]  i_rs_id,
    input  logic [NB_ADDR-1:0]  i_rt_id,
    input  logic                i_uses_rs_id,
    input  logic                i_uses_rt_id,
    input  logic [NB_ADDR-1:0]  i_rd_id,
    input  logic                i_wr_enb_id,
    input  logic                i_mem_read_id,
    input  logic                i_flush,
    output logic                o_stall,
    output logic [NB_ADDR-1:0]  o_rf_rd_ex_mem,
    output logic                o_rf_wr_enb_ex_mem,
    output logic [NB_ADDR-1:0]  o_rf_rd_mem_wb,
    output logic                o_rf_wr_enb_mem_wb,
    output logic                o_pipe_empty,
    output logic [NB_COUNT-1:0] o_stall_count
);

    typedef struct packed {
        logic               valid;
        logic [NB_ADDR-1:0] rd;
        logic               wr_enb;
        logic               is_load;
    } entry_t;

    entry_t              id_ex;
    entry_t              ex_mem;
    entry_t              mem_wb;
    entry_t              id_entry;
    logic                hazard;
    logic [NB_COUNT-1:0] stall_count;

    always_comb begin
        hazard = i_valid_id & id_ex.valid & id_ex.is_load & id_ex.wr_enb &
                 ((i_uses_rs_id & (i_rs_id == id_ex.rd)) |
                  (i_uses_rt_id & (i_rt_id == id_ex.rd)));
        // A squashed instruction never needs to wait for its operand.
        o_stall = hazard & ~i_flush;
    end

    always_comb begin
        id_entry = '0;
        if (i_valid_id && !i_flush && !o_stall) begin
            id_entry.valid   = 1'b1;
            id_entry.rd      = i_rd_id;
            id_entry.wr_enb  = i_wr_enb_id & (i_rd_id != '0);
            id_entry.is_load = i_mem_read_id;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            id_ex       <= '0;
            ex_mem      <= '0;
            mem_wb      <= '0;
            stall_count <= '0;
        end else if (i_enable) begin
            mem_wb <= ex_mem;
            ex_mem <= id_ex;
            id_ex  <= id_entry;
            if (o_stall && (stall_count != '1)) begin
                stall_count <= stall_count + NB_COUNT'(1);
            end
        end
    end

    always_comb begin
        o_rf_rd_ex_mem     = ex_mem.rd;
        o_rf_wr_enb_ex_mem = ex_mem.wr_enb;
        o_rf_rd_mem_wb     = mem_wb.rd;
        o_rf_wr_enb_mem_wb = mem_wb.wr_enb;
        o_pipe_empty       = ~(id_ex.valid | ex_mem.valid | mem_wb.valid);
        o_stall_count      = stall_count;
    end

endmodule
